// File: rtl/cl_ocl_csr_pkg.sv
// Shared definitions for the OCL BAR control/status responder.
// Covers the register offsets, the AXI response codes, and the FSM state types.
package cl_ocl_csr_pkg;

    localparam logic [11:0] ADDR_ID       = 12'h000;
    localparam logic [11:0] ADDR_SCRATCH  = 12'h004;
    localparam logic [11:0] ADDR_CTRL     = 12'h008;
    localparam logic [11:0] ADDR_STATUS   = 12'h00C;
    localparam logic [11:0] ADDR_CYCLE_LO = 12'h010;
    localparam logic [11:0] ADDR_CYCLE_HI = 12'h014;
    localparam logic [11:0] ADDR_PENDING  = 12'h018;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_RESP} r_state_e;

    // Byte-lane merge used by every strobed register write
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_value,
                                                input logic [31:0] new_value,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[b*8 +: 8] = strb[b] ? new_value[b*8 +: 8] : old_value[b*8 +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/cl_ocl_csr_responder.sv
// AXI4-Lite responder for the OCL BAR.
// Provides ID, scratch, control, status, a cycle counter and a sticky event register.
module cl_ocl_csr_responder
    import cl_ocl_csr_pkg::*;
#(
    parameter logic [31:0] ID_VALUE   = 32'hF15E_0001,
    parameter int          NUM_EVENTS = 8
) (
    input  logic                  clk_main_a0,
    input  logic                  rst_main_n,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_awaddr,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic [1:0]            s_bresp,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [31:0]           s_araddr,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic [31:0]           ctrl_o,
    input  logic [31:0]           status_i,
    input  logic [NUM_EVENTS-1:0] event_i
);

    w_state_e w_state, w_state_next;
    r_state_e r_state, r_state_next;

    logic                  w_accept;
    logic                  r_accept;
    logic [11:0]           w_offset;
    logic [11:0]           r_offset;
    logic [1:0]            wr_resp;
    logic [31:0]           rd_value;
    logic [1:0]            rd_resp;
    logic [31:0]           scratch;
    logic [31:0]           ctrl;
    logic [31:0]           status_q;
    logic [63:0]           cycle_count;
    logic [31:0]           cycle_hi_snap;
    logic [NUM_EVENTS-1:0] pending;
    logic [NUM_EVENTS-1:0] pending_clear;
    logic [31:0]           pending_ext;
    logic                  unused_addr_bits;

    // Only the word index selects a register; the rest of the address is don't-care
    assign w_offset = {s_awaddr[11:2], 2'b00};
    assign r_offset = {s_araddr[11:2], 2'b00};
    assign unused_addr_bits = ^{s_awaddr[31:12], s_awaddr[1:0], s_araddr[31:12], s_araddr[1:0]};

    assign ctrl_o = ctrl;

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_next;
            r_state <= r_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state;
        s_awready    = 1'b0;
        s_wready     = 1'b0;
        s_bvalid     = 1'b0;
        w_accept     = 1'b0;
        case (w_state)
            W_IDLE: begin
                w_accept  = s_awvalid & s_wvalid;
                s_awready = w_accept;
                s_wready  = w_accept;
                if (w_accept) w_state_next = W_RESP;
            end
            W_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state;
        s_arready    = 1'b0;
        s_rvalid     = 1'b0;
        r_accept     = 1'b0;
        case (r_state)
            R_IDLE: begin
                r_accept  = s_arvalid;
                s_arready = s_arvalid;
                if (r_accept) r_state_next = R_RESP;
            end
            R_RESP: begin
                s_rvalid = 1'b1;
                if (s_rready) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        case (w_offset)
            ADDR_ID, ADDR_SCRATCH, ADDR_CTRL, ADDR_STATUS,
            ADDR_CYCLE_LO, ADDR_CYCLE_HI, ADDR_PENDING: wr_resp = RESP_OKAY;
            default:                                    wr_resp = RESP_SLVERR;
        endcase
    end

    always_comb begin
        pending_ext                 = '0;
        pending_ext[NUM_EVENTS-1:0] = pending;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            pending_clear[i] = w_accept && (w_offset == ADDR_PENDING) && s_wdata[i] && s_wstrb[i/8];
        end
    end

    always_comb begin
        rd_resp  = RESP_OKAY;
        rd_value = DEAD_BEEF;
        case (r_offset)
            ADDR_ID:       rd_value = ID_VALUE;
            ADDR_SCRATCH:  rd_value = scratch;
            ADDR_CTRL:     rd_value = ctrl;
            ADDR_STATUS:   rd_value = status_q;
            ADDR_CYCLE_LO: rd_value = cycle_count[31:0];
            ADDR_CYCLE_HI: rd_value = cycle_hi_snap;
            ADDR_PENDING:  rd_value = pending_ext;
            default:       rd_resp  = RESP_SLVERR;
        endcase
    end

    // Event set takes priority over a same-cycle write-one-to-clear
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            scratch     <= '0;
            ctrl        <= '0;
            status_q    <= '0;
            cycle_count <= '0;
            pending     <= '0;
            s_bresp     <= RESP_OKAY;
        end else begin
            status_q    <= status_i;
            cycle_count <= cycle_count + 64'd1;
            pending     <= (pending & ~pending_clear) | event_i;
            if (w_accept) begin
                s_bresp <= wr_resp;
                if (w_offset == ADDR_SCRATCH) scratch <= apply_wstrb(scratch, s_wdata, s_wstrb);
                if (w_offset == ADDR_CTRL)    ctrl    <= apply_wstrb(ctrl, s_wdata, s_wstrb);
            end
        end
    end

    // High word is latched with the low-word read so a LO/HI pair is coherent
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            s_rdata       <= '0;
            s_rresp       <= RESP_OKAY;
            cycle_hi_snap <= '0;
        end else if (r_accept) begin
            s_rdata <= rd_value;
            s_rresp <= rd_resp;
            if (r_offset == ADDR_CYCLE_LO) cycle_hi_snap <= cycle_count[63:32];
        end
    end

endmodule

// File: tb/tb_cl_ocl_csr_responder.sv
// Self-checking bench for cl_ocl_csr_responder.
// Expected responses are queued when a request is driven and compared when the response arrives.
module tb_cl_ocl_csr_responder;
    import cl_ocl_csr_pkg::*;

    localparam int          NUM_EVENTS = 8;
    localparam logic [31:0] ID_VALUE   = 32'hF15E_0001;

    logic                  clk_main_a0 = 1'b0;
    logic                  rst_main_n  = 1'b0;
    logic                  s_awvalid   = 1'b0;
    logic                  s_awready;
    logic [31:0]           s_awaddr    = '0;
    logic                  s_wvalid    = 1'b0;
    logic                  s_wready;
    logic [31:0]           s_wdata     = '0;
    logic [3:0]            s_wstrb     = '0;
    logic                  s_bvalid;
    logic                  s_bready    = 1'b1;
    logic [1:0]            s_bresp;
    logic                  s_arvalid   = 1'b0;
    logic                  s_arready;
    logic [31:0]           s_araddr    = '0;
    logic                  s_rvalid;
    logic                  s_rready    = 1'b1;
    logic [31:0]           s_rdata;
    logic [1:0]            s_rresp;
    logic [31:0]           ctrl_o;
    logic [31:0]           status_i    = '0;
    logic [NUM_EVENTS-1:0] event_i     = '0;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] tb_cycles  = '0;
    logic [63:0] cnt_offset = '0;
    logic [31:0] snap_model = '0;
    logic [33:0] rd_queue[$];
    logic [1:0]  wr_queue[$];

    cl_ocl_csr_responder #(
        .ID_VALUE   (ID_VALUE),
        .NUM_EVENTS (NUM_EVENTS)
    ) dut (
        .clk_main_a0 (clk_main_a0),
        .rst_main_n  (rst_main_n),
        .s_awvalid   (s_awvalid),
        .s_awready   (s_awready),
        .s_awaddr    (s_awaddr),
        .s_wvalid    (s_wvalid),
        .s_wready    (s_wready),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_bvalid    (s_bvalid),
        .s_bready    (s_bready),
        .s_bresp     (s_bresp),
        .s_arvalid   (s_arvalid),
        .s_arready   (s_arready),
        .s_araddr    (s_araddr),
        .s_rvalid    (s_rvalid),
        .s_rready    (s_rready),
        .s_rdata     (s_rdata),
        .s_rresp     (s_rresp),
        .ctrl_o      (ctrl_o),
        .status_i    (status_i),
        .event_i     (event_i)
    );

    always #5 clk_main_a0 = ~clk_main_a0;

    // Free-running reference for the DUT cycle counter once it has been preloaded
    always @(posedge clk_main_a0) tb_cycles <= tb_cycles + 64'd1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyRead(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                             input int rready_delay, input bit is_cycle_lo, input string tag);
        logic [33:0] exp_entry;
        logic [63:0] live;
        int          waited;
        @(negedge clk_main_a0);
        s_rready  = (rready_delay == 0);
        s_arvalid = 1'b1;
        s_araddr  = addr;
        #1;
        waited = 0;
        while (!s_arready && waited < 20) begin
            @(negedge clk_main_a0);
            #1;
            waited++;
        end
        if (!s_arready) begin
            checkOutput({tag, "_arready_timeout"}, 0, 1);
            s_arvalid = 1'b0;
            s_rready  = 1'b1;
            return;
        end
        if (is_cycle_lo) begin
            live       = tb_cycles + cnt_offset;
            exp_data   = live[31:0];
            snap_model = live[63:32];
        end
        rd_queue.push_back({exp_resp, exp_data});
        checkOutput({tag, "_rvalid_early"}, s_rvalid, 0);
        @(posedge clk_main_a0);
        #1;
        s_arvalid = 1'b0;
        checkOutput({tag, "_rvalid"}, s_rvalid, 1);
        for (int i = 0; i < rready_delay; i++) begin
            @(negedge clk_main_a0);
            checkOutput({tag, "_rvalid_hold"}, s_rvalid, 1);
            checkOutput({tag, "_rdata_hold"}, s_rdata, exp_data);
        end
        @(negedge clk_main_a0);
        s_rready = 1'b1;
        #1;
        waited = 0;
        while (!(s_rvalid && s_rready) && waited < 20) begin
            @(negedge clk_main_a0);
            #1;
            waited++;
        end
        exp_entry = rd_queue.pop_front();
        if (s_rvalid && s_rready) begin
            checkOutput({tag, "_rdata"}, s_rdata, exp_entry[31:0]);
            checkOutput({tag, "_rresp"}, s_rresp, exp_entry[33:32]);
        end else begin
            checkOutput({tag, "_rvalid_timeout"}, 0, 1);
        end
        @(posedge clk_main_a0);
        #1;
        checkOutput({tag, "_rvalid_drop"}, s_rvalid, 0);
    endtask

    task automatic applyWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input logic [1:0] exp_resp, input logic [31:0] exp_ctrl,
                              input logic [NUM_EVENTS-1:0] ev, input int bready_delay, input string tag);
        logic [1:0] exp_b;
        int         waited;
        @(negedge clk_main_a0);
        s_bready  = (bready_delay == 0);
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_awaddr  = addr;
        s_wdata   = data;
        s_wstrb   = strb;
        event_i   = ev;
        #1;
        waited = 0;
        while (!s_awready && waited < 20) begin
            @(negedge clk_main_a0);
            #1;
            waited++;
        end
        if (!s_awready) begin
            checkOutput({tag, "_awready_timeout"}, 0, 1);
            s_awvalid = 1'b0;
            s_wvalid  = 1'b0;
            event_i   = '0;
            s_bready  = 1'b1;
            return;
        end
        checkOutput({tag, "_wready"}, s_wready, 1);
        wr_queue.push_back(exp_resp);
        @(posedge clk_main_a0);
        #1;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        event_i   = '0;
        checkOutput({tag, "_bvalid"}, s_bvalid, 1);
        checkOutput({tag, "_ctrl"}, ctrl_o, exp_ctrl);
        for (int i = 0; i < bready_delay; i++) begin
            @(negedge clk_main_a0);
            s_awvalid = 1'b1;
            s_wvalid  = 1'b1;
            #1;
            checkOutput({tag, "_bvalid_hold"}, s_bvalid, 1);
            checkOutput({tag, "_awready_blocked"}, s_awready, 0);
            checkOutput({tag, "_bresp_hold"}, s_bresp, exp_resp);
        end
        @(negedge clk_main_a0);
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b1;
        #1;
        waited = 0;
        while (!(s_bvalid && s_bready) && waited < 20) begin
            @(negedge clk_main_a0);
            #1;
            waited++;
        end
        exp_b = wr_queue.pop_front();
        if (s_bvalid && s_bready) begin
            checkOutput({tag, "_bresp"}, s_bresp, exp_b);
        end else begin
            checkOutput({tag, "_bvalid_timeout"}, 0, 1);
        end
        @(posedge clk_main_a0);
        #1;
        checkOutput({tag, "_bvalid_drop"}, s_bvalid, 0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [33:0] rd_exp;
        logic [1:0]  wr_exp;
        localparam logic [31:0] CTRL_A = 32'h0034_0078;

        #12;
        checkOutput("reset_awready", s_awready, 0);
        checkOutput("reset_arready", s_arready, 0);
        checkOutput("reset_bvalid", s_bvalid, 0);
        checkOutput("reset_rvalid", s_rvalid, 0);
        checkOutput("reset_rdata", s_rdata, 0);
        checkOutput("reset_rresp", s_rresp, 0);
        checkOutput("reset_bresp", s_bresp, 0);
        checkOutput("reset_ctrl", ctrl_o, 0);
        @(negedge clk_main_a0);
        rst_main_n = 1'b1;
        $display("[TB] reset released");

        applyRead({20'h0, ADDR_ID}, ID_VALUE, RESP_OKAY, 0, 1'b0, "read_id");
        applyWrite({20'h0, ADDR_CTRL}, 32'h1234_5678, 4'b0101, RESP_OKAY, CTRL_A, '0, 0, "write_ctrl");
        applyRead({20'h0, ADDR_CTRL}, CTRL_A, RESP_OKAY, 0, 1'b0, "read_ctrl");

        applyWrite({20'h0, ADDR_SCRATCH}, 32'hA5A5_5A5A, 4'hF, RESP_OKAY, CTRL_A, '0, 10, "write_scratch_bp");
        applyRead(32'hABC0_0007, 32'hA5A5_5A5A, RESP_OKAY, 0, 1'b0, "read_scratch_alias");

        applyRead(32'h0000_0100, DEAD_BEEF, RESP_SLVERR, 0, 1'b0, "read_unmapped");
        applyRead(32'h0000_001C, DEAD_BEEF, RESP_SLVERR, 0, 1'b0, "read_unmapped_1c");
        applyWrite(32'h0000_0100, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR, CTRL_A, '0, 0, "write_unmapped");
        applyWrite({20'h0, ADDR_ID}, 32'h0000_0000, 4'hF, RESP_OKAY, CTRL_A, '0, 0, "write_ro_id");
        applyRead({20'h0, ADDR_ID}, ID_VALUE, RESP_OKAY, 0, 1'b0, "read_id_after_ro");
        applyRead({20'h0, ADDR_SCRATCH}, 32'hA5A5_5A5A, RESP_OKAY, 0, 1'b0, "read_scratch_kept");
        applyRead({20'h0, ADDR_CTRL}, CTRL_A, RESP_OKAY, 3, 1'b0, "read_ctrl_bp");

        @(negedge clk_main_a0);
        status_i = 32'hCAFE_F00D;
        applyRead({20'h0, ADDR_STATUS}, 32'hCAFE_F00D, RESP_OKAY, 0, 1'b0, "read_status");

        @(negedge clk_main_a0);
        event_i = 8'h08;
        @(negedge clk_main_a0);
        event_i = '0;
        applyRead({20'h0, ADDR_PENDING}, 32'h0000_0008, RESP_OKAY, 0, 1'b0, "pending_set");
        applyWrite({20'h0, ADDR_PENDING}, 32'h0000_0008, 4'h1, RESP_OKAY, CTRL_A, 8'h08, 0, "w1c_vs_event");
        applyRead({20'h0, ADDR_PENDING}, 32'h0000_0008, RESP_OKAY, 0, 1'b0, "pending_set_wins");
        applyWrite({20'h0, ADDR_PENDING}, 32'h0000_0008, 4'h1, RESP_OKAY, CTRL_A, '0, 0, "w1c_clear");
        applyRead({20'h0, ADDR_PENDING}, 32'h0000_0000, RESP_OKAY, 0, 1'b0, "pending_cleared");
        @(negedge clk_main_a0);
        event_i = 8'h81;
        @(negedge clk_main_a0);
        event_i = '0;
        applyWrite({20'h0, ADDR_PENDING}, 32'h0000_0081, 4'h0, RESP_OKAY, CTRL_A, '0, 0, "w1c_no_strobe");
        applyRead({20'h0, ADDR_PENDING}, 32'h0000_0081, RESP_OKAY, 0, 1'b0, "pending_no_strobe");
        applyWrite({20'h0, ADDR_PENDING}, 32'hFFFF_FFFF, 4'hF, RESP_OKAY, CTRL_A, '0, 0, "w1c_all");
        applyRead({20'h0, ADDR_PENDING}, 32'h0000_0000, RESP_OKAY, 0, 1'b0, "pending_all_clear");

        // Preload the counter just below the 32-bit carry
        @(negedge clk_main_a0);
        force dut.cycle_count = 64'h0000_0000_FFFF_FFF0;
        @(negedge clk_main_a0);
        release dut.cycle_count;
        cnt_offset = 64'h0000_0000_FFFF_FFF0 - tb_cycles;
        applyRead({20'h0, ADDR_CYCLE_LO}, 32'h0, RESP_OKAY, 0, 1'b1, "cycle_lo_pre");
        repeat (20) @(negedge clk_main_a0);
        applyRead({20'h0, ADDR_CYCLE_HI}, snap_model, RESP_OKAY, 0, 1'b0, "cycle_hi_snap");
        applyRead({20'h0, ADDR_CYCLE_LO}, 32'h0, RESP_OKAY, 0, 1'b1, "cycle_lo_post");
        applyRead({20'h0, ADDR_CYCLE_HI}, snap_model, RESP_OKAY, 0, 1'b0, "cycle_hi_post");

        // Read and write of the same register accepted together
        @(negedge clk_main_a0);
        s_rready  = 1'b1;
        s_bready  = 1'b1;
        s_arvalid = 1'b1;
        s_araddr  = {20'h0, ADDR_SCRATCH};
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_awaddr  = {20'h0, ADDR_SCRATCH};
        s_wdata   = 32'h0BAD_F00D;
        s_wstrb   = 4'hF;
        #1;
        checkOutput("rw_same_arready", s_arready, 1);
        checkOutput("rw_same_awready", s_awready, 1);
        rd_queue.push_back({RESP_OKAY, 32'hA5A5_5A5A});
        wr_queue.push_back(RESP_OKAY);
        @(posedge clk_main_a0);
        #1;
        s_arvalid = 1'b0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        checkOutput("rw_same_rvalid", s_rvalid, 1);
        checkOutput("rw_same_bvalid", s_bvalid, 1);
        rd_exp = rd_queue.pop_front();
        wr_exp = wr_queue.pop_front();
        checkOutput("rw_same_rdata", s_rdata, rd_exp[31:0]);
        checkOutput("rw_same_bresp", s_bresp, wr_exp);
        @(posedge clk_main_a0);
        #1;
        applyRead({20'h0, ADDR_SCRATCH}, 32'h0BAD_F00D, RESP_OKAY, 0, 1'b0, "rw_same_after");

        @(negedge clk_main_a0);
        rst_main_n = 1'b0;
        #1;
        checkOutput("reset2_ctrl", ctrl_o, 0);
        checkOutput("reset2_rdata", s_rdata, 0);
        checkOutput("reset2_bvalid", s_bvalid, 0);
        checkOutput("reset2_rvalid", s_rvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cl_ocl_csr_responder.md
# cl_ocl_csr_responder

AXI4-Lite responder terminating the shell's OCL BAR in the custom logic, downstream of the OCL register slice. It provides a small control/status register file: ID, scratch, control outputs, sampled status, a 64-bit cycle counter and a sticky event/pending register. Host software uses it for bring-up, liveness checks and simulator control, independent of the main simulator shim.

## Interface
- ID_VALUE, 32'hF1_5E_0001, value returned by the ID register
- NUM_EVENTS, 8, width of the event/pending vector (1..32)
- clk_main_a0  in  1  clock
- rst_main_n  in  1  reset, asynchronous, active-low
- s_awvalid / s_awready  in / out  1  write address handshake
- s_awaddr  in  32  write byte address
- s_wvalid / s_wready  in / out  1  write data handshake
- s_wdata  in  32  write data
- s_wstrb  in  4  byte enables
- s_bvalid / s_bready  out / in  1  write response handshake
- s_bresp  out  2  write response
- s_arvalid / s_arready  in / out  1  read address handshake
- s_araddr  in  32  read byte address
- s_rvalid / s_rready  out / in  1  read data handshake
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- ctrl_o  out  32  CTRL register contents
- status_i  in  32  status word, sampled every cycle
- event_i  in  NUM_EVENTS  single-cycle event pulses

## Operation
- Decode uses s_*addr[11:2]. s_*addr[1:0] and s_*addr[31:12] are ignored.
- Register map:
  - 0x00 ID: RO.
  - 0x04 SCRATCH: RW, strobed.
  - 0x08 CTRL: RW, strobed, drives ctrl_o.
  - 0x0C STATUS: RO, status_i registered one cycle.
  - 0x10 CYCLE_LO: RO.
  - 0x14 CYCLE_HI: RO. Returns the high-word snapshot taken at the last CYCLE_LO read.
  - 0x18 PENDING: W1C per strobed byte, upper bits read 0.
- Writes to RO registers: accepted, no effect, OKAY.
- Any other offset: SLVERR. Reads of such offsets return 32'hDEAD_BEEF.
- Write FSM has states W_IDLE and W_RESP.
  - W_IDLE: s_awready = s_wready = s_awvalid & s_wvalid. AW and W are accepted only in the same cycle.
  - On acceptance: the register is updated and the FSM moves to W_RESP.
  - W_RESP: s_bvalid=1. On s_bready the FSM returns to W_IDLE.
- Read FSM has states R_IDLE and R_RESP.
  - R_IDLE: s_arready = s_arvalid.
  - On acceptance: s_rdata and s_rresp are captured and the FSM moves to R_RESP.
  - R_RESP: s_rvalid=1, data held stable until s_rready.
- The read and write channels are independent. Each has one transaction outstanding.
- PENDING: bit set by event_i[i]. The same-cycle W1C of that bit loses, so set wins.
- Cycle counter: 64-bit, increments every cycle, wraps from all-ones to 0.

## Timing
- Reset values:
  - All ready/valid outputs 0, s_bresp, s_rresp and s_rdata 0.
  - ctrl_o, SCRATCH, PENDING, counter and snapshot 0.
  - Both FSMs return to idle. Reset mid-transaction drops the response.
- Write acceptance in cycle N:
  - Register visible on ctrl_o and to reads from cycle N+1.
  - s_bvalid is high from N+1.
- Read acceptance in cycle N: s_rvalid is high from N+1.
- After a response handshake in cycle M, the next acceptance on that channel is no earlier than M+1. Peak throughput is one transaction per 2 cycles per channel.
- Read and write to the same offset accepted in the same cycle: the read returns the pre-write value.
- CYCLE_LO returns the counter value of its acceptance cycle. The snapshot of bits [63:32] is taken in the same cycle.
- Response outputs hold stable while valid and not ready.

## Structure
- Package cl_ocl_csr_pkg holds:
  - register offset localparams
  - AXI resp constants: OKAY=2'b00, SLVERR=2'b10
  - w_state_e and r_state_e enums
  - the DEAD_BEEF constant
- Single module with no sub-module. The register file, counter and both FSMs fit in about 200 lines.

## Test plan
- Reset release, then read 0x00 → rdata=ID_VALUE, rresp=OKAY, rvalid exactly one cycle after arready.
- Write 0x08 data 0x1234_5678 wstrb 4'b0101 after CTRL=0 → ctrl_o=0x0034_0078 from cycle after acceptance, bresp=OKAY.
- Hold s_bready=0 for 10 cycles after a write → bvalid held, no second AW/W accepted, then bready=1 completes.
- Read 0x100 → rresp=SLVERR, rdata=0xDEAD_BEEF. Write 0x100 → bresp=SLVERR, no register changes.
- Pulse event_i[3] while writing 0x18 wdata=0x8 wstrb=1 in the same cycle → PENDING[3] remains 1. A later identical W1C clears it.
- Preload counter near 2^32 via force, read CYCLE_LO then CYCLE_HI across the carry → HI matches the snapshot, not the live value.
